// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels, parity selectors.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PRESCALE_W     = 6;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period counter: counts 0..P-1 while enabled and flags the last cycle.
// A prescale of 0 behaves as a one-cycle bit.
module uart_tx_bit_timer
    import uart_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic                  en_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  bit_done_o
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [PRESCALE_W-1:0] last;

    always_comb begin
        last       = (prescale_i == '0) ? '0 : prescale_i - PRESCALE_W'(1);
        bit_done_o = en_i && (cnt_q == last);
        cnt_d      = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = bit_done_o ? '0 : cnt_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_WIDTH bits LSB first, optional parity, stop.
// Define UART_TX_SKID_EN to add a one-entry holding buffer and the Buf_Full port.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  TX_OUT,
    output logic                  Busy
`ifdef UART_TX_SKID_EN
    ,
    output logic                  Buf_Full
`endif
);

    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic [PRESCALE_W-1:0] presc_q;
    logic [IW-1:0]         idx_q;
    logic                  tx_q;
    logic                  busy_q;

    logic                  bit_done;
    logic                  start_frame;
    logic [DATA_WIDTH-1:0] nxt_data;
    logic                  nxt_pe;
    logic                  nxt_pt;
    logic [PRESCALE_W-1:0] nxt_ps;
    logic                  nxt_par;

`ifdef UART_TX_SKID_EN
    logic [DATA_WIDTH-1:0] buf_data_q;
    logic                  buf_pe_q;
    logic                  buf_pt_q;
    logic [PRESCALE_W-1:0] buf_ps_q;
    logic                  buf_full_q;
    logic                  stop_end;

    assign stop_end = (state_q == STOP) && bit_done;
`endif

    // A new frame starts from IDLE, or back-to-back from the end of STOP when buffered.
    always_comb begin
        nxt_data = P_DATA;
        nxt_pe   = PAR_EN;
        nxt_pt   = PAR_TYP;
        nxt_ps   = Prescale;
`ifdef UART_TX_SKID_EN
        start_frame = ((state_q == IDLE) && Data_Valid) ||
                      (stop_end && (buf_full_q || Data_Valid));
        if (stop_end && buf_full_q) begin
            nxt_data = buf_data_q;
            nxt_pe   = buf_pe_q;
            nxt_pt   = buf_pt_q;
            nxt_ps   = buf_ps_q;
        end
`else
        start_frame = (state_q == IDLE) && Data_Valid;
`endif
        nxt_par = (nxt_pt == PAR_EVEN) ? ^nxt_data : ~^nxt_data;
    end

    uart_tx_bit_timer u_timer (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .load_i     (start_frame),
        .en_i       (busy_q),
        .prescale_i (presc_q),
        .bit_done_o (bit_done)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            presc_q   <= '0;
            idx_q     <= '0;
            tx_q      <= STOP_BIT;
            busy_q    <= 1'b0;
        end else if (start_frame) begin
            state_q   <= START;
            shreg_q   <= nxt_data;
            par_en_q  <= nxt_pe;
            par_bit_q <= nxt_par;
            presc_q   <= nxt_ps;
            idx_q     <= '0;
            tx_q      <= START_BIT;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                START: if (bit_done) begin
                    state_q <= DATA;
                    tx_q    <= shreg_q[0];
                end
                DATA: if (bit_done) begin
                    if (idx_q == IW'(DATA_WIDTH - 1)) begin
                        state_q <= par_en_q ? PARITY : STOP;
                        tx_q    <= par_en_q ? par_bit_q : STOP_BIT;
                    end else begin
                        idx_q   <= idx_q + IW'(1);
                        shreg_q <= shreg_q >> 1;
                        tx_q    <= shreg_q[1];
                    end
                end
                PARITY: if (bit_done) begin
                    state_q <= STOP;
                    tx_q    <= STOP_BIT;
                end
                STOP: if (bit_done) begin
                    state_q <= IDLE;
                    tx_q    <= STOP_BIT;
                    busy_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef UART_TX_SKID_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            buf_data_q <= '0;
            buf_pe_q   <= 1'b0;
            buf_pt_q   <= 1'b0;
            buf_ps_q   <= '0;
            buf_full_q <= 1'b0;
        end else if (stop_end && buf_full_q) begin
            buf_full_q <= 1'b0;
        end else if (busy_q && !buf_full_q && Data_Valid && !stop_end) begin
            buf_data_q <= P_DATA;
            buf_pe_q   <= PAR_EN;
            buf_pt_q   <= PAR_TYP;
            buf_ps_q   <= Prescale;
            buf_full_q <= 1'b1;
        end
    end

    assign Buf_Full = buf_full_q;
`endif

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-cycle waveform model built from frame rules,
// plus literal frame pins, a behavioural line receiver and randomized traffic.
module tb_uart_tx;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = '0;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd16;
    logic       TX_OUT;
    logic       Busy;
`ifdef UART_TX_SKID_EN
    logic       Buf_Full;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic samples [4096];

    always #5 CLK = ~CLK;

    uart_tx #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
`ifdef UART_TX_SKID_EN
        ,
        .Buf_Full   (Buf_Full)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Line levels of one frame, bit 0 first.
    function automatic void frame_bits(input logic [7:0] d, input logic pe, input logic pt,
                                       output logic [10:0] lb, output int nb);
        lb = '0;
        lb[0] = 1'b0;
        for (int i = 0; i < 8; i++) lb[i+1] = d[i];
        nb = 9;
        if (pe) begin
            lb[nb] = pt ? ~^d : ^d;
            nb++;
        end
        lb[nb] = 1'b1;
        nb++;
    endfunction

    // Reference model: a queue of expected line levels, one entry per busy cycle.
    logic mq [$];
`ifdef UART_TX_SKID_EN
    logic       mbuf = 1'b0;
    logic [7:0] bd;
    logic       bpe, bpt;
    logic [5:0] bps;
`endif

    function automatic void push_frame(input logic [7:0] d, input logic pe, input logic pt,
                                       input logic [5:0] ps);
        logic [10:0] lb;
        int nb;
        int p;
        p = (ps == 0) ? 1 : int'(ps);
        frame_bits(d, pe, pt, lb, nb);
        for (int b = 0; b < nb; b++)
            for (int c = 0; c < p; c++) mq.push_back(lb[b]);
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mq.delete();
`ifdef UART_TX_SKID_EN
            mbuf = 1'b0;
`endif
        end else begin
            logic was_busy;
            was_busy = (mq.size() != 0);
            if (was_busy) void'(mq.pop_front());
            if (!was_busy) begin
                if (Data_Valid) push_frame(P_DATA, PAR_EN, PAR_TYP, Prescale);
            end
`ifdef UART_TX_SKID_EN
            else if (mq.size() == 0) begin
                if (mbuf) begin
                    push_frame(bd, bpe, bpt, bps);
                    mbuf = 1'b0;
                end else if (Data_Valid) begin
                    push_frame(P_DATA, PAR_EN, PAR_TYP, Prescale);
                end
            end else if (!mbuf && Data_Valid) begin
                mbuf = 1'b1;
                bd = P_DATA; bpe = PAR_EN; bpt = PAR_TYP; bps = Prescale;
            end
`endif
        end
    end

    always @(negedge CLK) begin
        if (RST) begin
            chk("tx_line", {31'd0, TX_OUT}, (mq.size() != 0) ? {31'd0, mq[0]} : 32'd1);
            chk("busy", {31'd0, Busy}, {31'd0, (mq.size() != 0)});
`ifdef UART_TX_SKID_EN
            chk("buf_full", {31'd0, Buf_Full}, {31'd0, mbuf});
`endif
        end
    end

    // Sends one frame, scrambling inputs while busy; optionally pulses 0x55 at busy cycle pulse_at.
    task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input logic [5:0] ps, input int pulse_at, input string nm,
                             output int cnt);
        logic [10:0] lb;
        int nb;
        int p;
        int exp_len;
        @(negedge CLK);
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = ps; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        cnt = 0;
        while (Busy === 1'b1 && cnt < 3000) begin
            samples[cnt] = TX_OUT;
            if (cnt == pulse_at) begin
                P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = ps; Data_Valid = 1'b1;
            end else begin
                Data_Valid = 1'b0;
                P_DATA = 8'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
                Prescale = 6'($urandom);
            end
            cnt++;
            @(negedge CLK);
        end
        Data_Valid = 1'b0;
        p = (ps == 0) ? 1 : int'(ps);
        exp_len = (10 + int'(pe)) * p;
`ifdef UART_TX_SKID_EN
        if (pulse_at >= 0) exp_len = exp_len + 10 * p;
`endif
        chk({nm, "_len"}, cnt, exp_len);
        frame_bits(d, pe, pt, lb, nb);
        for (int b = 0; b < nb; b++)
            chk({nm, "_bit"}, {31'd0, samples[b*p + p/2]}, {31'd0, lb[b]});
    endtask

    // Behavioural receiver sampling mid-bit; called while the start bit is on the line.
    task automatic rx_byte(input int p, input logic pe, input logic pt,
                           output logic [7:0] d, output logic err);
        int g;
        g = 0;
        err = 1'b0;
        d = '0;
        while (TX_OUT !== 1'b0 && g < 2000) begin
            @(negedge CLK);
            g++;
        end
        if (g >= 2000) err = 1'b1;
        repeat (p/2) @(negedge CLK);
        if (TX_OUT !== 1'b0) err = 1'b1;
        for (int i = 0; i < 8; i++) begin
            repeat (p) @(negedge CLK);
            d[i] = TX_OUT;
        end
        if (pe) begin
            repeat (p) @(negedge CLK);
            if (TX_OUT !== (pt ? ~^d : ^d)) err = 1'b1;
        end
        repeat (p) @(negedge CLK);
        if (TX_OUT !== 1'b1) err = 1'b1;
    endtask

    task automatic wait_idle(input string nm);
        int g;
        g = 0;
        while (Busy !== 1'b0 && g < 3000) begin
            @(negedge CLK);
            g++;
        end
        chk({nm, "_idle_timeout"}, {31'd0, (g >= 3000)}, 32'd0);
    endtask

    task automatic loop_send(input logic [7:0] d, input logic pt, input string nm);
        logic [7:0] rd;
        logic err;
        @(negedge CLK);
        P_DATA = d; PAR_EN = 1'b1; PAR_TYP = pt; Prescale = 6'd16; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        rx_byte(16, 1'b1, pt, rd, err);
        chk({nm, "_data"}, {24'd0, rd}, {24'd0, d});
        chk({nm, "_err"}, {31'd0, err}, 32'd0);
        wait_idle(nm);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int low;
        logic seen;
        logic [9:0] lit_f0;
        logic [9:0] lit_0f;
        lit_f0 = 10'b1111100000;
        lit_0f = 10'b1000011110;

        repeat (3) @(negedge CLK);
        chk("reset_tx", {31'd0, TX_OUT}, 32'd1);
        chk("reset_busy", {31'd0, Busy}, 32'd0);
`ifdef UART_TX_SKID_EN
        chk("reset_buf", {31'd0, Buf_Full}, 32'd0);
`endif
        #2 RST = 1'b1;

        run_frame(8'hF0, 1'b0, 1'b0, 6'd16, -1, "f0", cnt);
        chk("f0_len_lit", cnt, 160);
        for (int k = 0; k < 10; k++) chk("f0_lit", {31'd0, samples[k*16 + 8]}, {31'd0, lit_f0[k]});

        run_frame(8'hF0, 1'b1, 1'b1, 6'd16, -1, "f0_odd", cnt);
        chk("f0_odd_len_lit", cnt, 176);
        chk("f0_odd_par_lit", {31'd0, samples[9*16 + 8]}, 32'd1);
        run_frame(8'hF8, 1'b1, 1'b0, 6'd16, -1, "f8_even", cnt);
        chk("f8_even_par_lit", {31'd0, samples[9*16 + 8]}, 32'd1);
        run_frame(8'hF0, 1'b1, 1'b0, 6'd16, -1, "f0_even", cnt);
        chk("f0_even_par_lit", {31'd0, samples[9*16 + 8]}, 32'd0);

        run_frame(8'hF0, 1'b0, 1'b0, 6'd16, 40, "dv_busy", cnt);
`ifdef UART_TX_SKID_EN
        chk("skid_len_lit", cnt, 320);
        chk("skid_2nd_d0_lit", {31'd0, samples[160 + 16 + 8]}, 32'd1);
        chk("skid_2nd_d1_lit", {31'd0, samples[160 + 32 + 8]}, 32'd0);
`else
        chk("noskid_len_lit", cnt, 160);
        repeat (30) begin
            @(negedge CLK);
            chk("no_queue", {31'd0, Busy}, 32'd0);
        end
`endif

        @(negedge CLK);
        P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd16; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        repeat (70) @(negedge CLK);
        chk("pre_reset_busy", {31'd0, Busy}, 32'd1);
        #2 RST = 1'b0;
        #1;
        chk("abort_tx", {31'd0, TX_OUT}, 32'd1);
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        repeat (2) @(negedge CLK);
        #2 RST = 1'b1;
        run_frame(8'hA5, 1'b1, 1'b0, 6'd16, -1, "after_reset", cnt);

        run_frame(8'hF0, 1'b0, 1'b0, 6'd32, -1, "p32", cnt);
        chk("p32_len_lit", cnt, 320);
        for (int k = 0; k < 10; k++) chk("p32_lit", {31'd0, samples[k*32 + 16]}, {31'd0, lit_f0[k]});
        run_frame(8'h0F, 1'b0, 1'b0, 6'd8, -1, "p8", cnt);
        chk("p8_len_lit", cnt, 80);
        for (int k = 0; k < 10; k++) chk("p8_lit", {31'd0, samples[k*8 + 4]}, {31'd0, lit_0f[k]});
        run_frame(8'hAA, 1'b0, 1'b0, 6'd4, -1, "p4", cnt);
        chk("p4_len_lit", cnt, 40);
        run_frame(8'h3C, 1'b1, 1'b1, 6'd0, -1, "p0", cnt);
        chk("p0_len_lit", cnt, 11);

        loop_send(8'hAA, 1'b1, "loop_aa");
        loop_send(8'h55, 1'b0, "loop_55");

        @(negedge CLK);
        Prescale = 6'd2; PAR_EN = 1'b0; Data_Valid = 1'b1;
        seen = 1'b0;
        low = 0;
        repeat (120) begin
            @(negedge CLK);
            P_DATA = 8'($urandom);
            if (Busy) begin
`ifndef UART_TX_SKID_EN
                if (seen && low > 0) chk("held_dv_gap", low, 1);
`endif
                seen = 1'b1;
                low = 0;
            end else begin
                low++;
            end
        end
        Data_Valid = 1'b0;
        wait_idle("held_dv");

        repeat (600) begin
            @(negedge CLK);
            Data_Valid = ($urandom_range(0, 3) == 0);
            P_DATA = 8'($urandom);
            PAR_EN = 1'($urandom);
            PAR_TYP = 1'($urandom);
            Prescale = 6'($urandom_range(0, 4));
        end
        Data_Valid = 1'b0;
        wait_idle("random");
        repeat (5) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
